// File: rtl/ok_btpipe_out_fifo.sv
// ok_btpipe_out_fifo: word FIFO feeding okBTPipeOut, arming ep_ready once a full block is stored.
module ok_btpipe_out_fifo #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  ti_clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic [15:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] BW   = BLOCK_WORDS[DEPTH_LOG2:0];
  typedef enum logic [1:0] {IDLE, ARMED, XFER} state_t;
  logic [15:0]           mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d, blk_cnt_q, blk_cnt_d, blk_inc;
  state_t                state_q, state_d;
  logic [15:0]           ep_datain_q, ep_datain_d;
  logic                  ep_ready_q, overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  push, pop;
  assign in_ready   = count_q != FULL;
  assign push       = in_valid & in_ready;
  assign pop        = ep_read & (state_q == XFER) & (count_q != '0);
  assign ep_datain  = ep_datain_q;
  assign ep_ready   = ep_ready_q;
  assign fill_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  always_comb begin
    count_d     = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    wr_ptr_d    = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d    = rd_ptr_q + DEPTH_LOG2'(pop);
    blk_inc     = blk_cnt_q + (DEPTH_LOG2+1)'(1);
    ep_datain_d = pop ? mem[rd_ptr_q] : ep_read ? 16'h0000 : ep_datain_q;
    overflow_d  = overflow_q | (in_valid & ~in_ready);
    underflow_d = underflow_q | (ep_read & ~pop) | (ep_blockstrobe & (state_q == IDLE));
    blk_cnt_d   = (state_q == ARMED && ep_blockstrobe) ? '0 : pop ? blk_inc : blk_cnt_q;
    state_d     = (state_q == IDLE  && count_q >= BW)        ? ARMED :
                  (state_q == ARMED && ep_blockstrobe)        ? XFER  :
                  (state_q == XFER  && pop && blk_inc == BW)  ? IDLE  : state_q;
  end
  // storage is left unreset; pointers alone define validity
  always_ff @(posedge ti_clk)
    if (push) mem[wr_ptr_q] <= in_data;
  always_ff @(posedge ti_clk) begin
    if (reset || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      blk_cnt_q   <= '0;
      state_q     <= IDLE;
      ep_datain_q <= 16'h0000;
      ep_ready_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      blk_cnt_q   <= blk_cnt_d;
      state_q     <= state_d;
      ep_datain_q <= ep_datain_d;
      ep_ready_q  <= state_d == ARMED;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_ok_btpipe_out_fifo.sv
// tb_ok_btpipe_out_fifo: large (1024/256) and small (16/4) instances against a queue-based model.
module tb_ok_btpipe_out_fifo;
  logic ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;
  logic [1:0]  reset = '0, flush = '0, in_valid = '0, ep_read = '0, ep_blockstrobe = '0;
  logic [1:0]  in_ready, ep_ready, overflow, underflow;
  logic [15:0] in_data [2] = '{16'h0, 16'h0};
  logic [15:0] ep_datain [2];
  logic [10:0] fill0;
  logic [4:0]  fill1;
  ok_btpipe_out_fifo #(.DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut0 (
    .ti_clk(ti_clk), .reset(reset[0]), .flush(flush[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ep_read(ep_read[0]),
    .ep_blockstrobe(ep_blockstrobe[0]), .ep_datain(ep_datain[0]), .ep_ready(ep_ready[0]),
    .fill_count(fill0), .overflow(overflow[0]), .underflow(underflow[0]));
  ok_btpipe_out_fifo #(.DEPTH_LOG2(4), .BLOCK_WORDS(4)) dut1 (
    .ti_clk(ti_clk), .reset(reset[1]), .flush(flush[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ep_read(ep_read[1]),
    .ep_blockstrobe(ep_blockstrobe[1]), .ep_datain(ep_datain[1]), .ep_ready(ep_ready[1]),
    .fill_count(fill1), .overflow(overflow[1]), .underflow(underflow[1]));
  // model: 0 = waiting for a block, 1 = block offered, 2 = host mid-block
  logic [15:0] q [2][$];
  int          mode [2] = '{0, 0};
  int          left [2] = '{0, 0};
  logic [15:0] edout [2] = '{16'h0, 16'h0};
  bit          eovf [2] = '{0, 0};
  bit          eunf [2] = '{0, 0};
  int          depth [2] = '{1024, 16};
  int          bw [2] = '{256, 4};
  int          total = 0, passed = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic upd(input int j, input bit rs, input bit fl, input bit vl, input logic [15:0] d,
                     input bit rd, input bit sb);
    int n;
    bit p;
    n = q[j].size();
    if (rs || fl) begin
      q[j].delete();
      mode[j] = 0; left[j] = 0; edout[j] = 16'h0; eovf[j] = 0; eunf[j] = 0;
      return;
    end
    p = rd && mode[j] == 2 && n > 0;
    if (p) edout[j] = q[j].pop_front();
    else if (rd) begin edout[j] = 16'h0; eunf[j] = 1; end
    if (vl) begin
      if (n == depth[j]) eovf[j] = 1;
      else q[j].push_back(d);
    end
    if (mode[j] == 0) begin
      if (sb) eunf[j] = 1;
      if (n >= bw[j]) mode[j] = 1;
    end else if (mode[j] == 1) begin
      if (sb) begin mode[j] = 2; left[j] = bw[j]; end
    end else if (p) begin
      left[j]--;
      if (left[j] == 0) mode[j] = 0;
    end
  endtask
  task automatic step(input int k, input bit rs, input bit fl, input bit vl, input logic [15:0] d,
                      input bit rd, input bit sb);
    reset = '0; flush = '0; in_valid = '0; ep_read = '0; ep_blockstrobe = '0;
    reset[k] = rs; flush[k] = fl; in_valid[k] = vl; ep_read[k] = rd; ep_blockstrobe[k] = sb;
    in_data[k] = d;
    chk("in_ready", {31'b0, in_ready[k]}, {31'b0, q[k].size() != depth[k]});
    @(posedge ti_clk);
    for (int j = 0; j < 2; j++)
      if (j == k) upd(j, rs, fl, vl, d, rd, sb);
      else upd(j, 0, 0, 0, 16'h0, 0, 0);
    #1;
    chk("ep_datain", {16'b0, ep_datain[k]}, {16'b0, edout[k]});
    chk("ep_ready", {31'b0, ep_ready[k]}, {31'b0, mode[k] == 1});
    chk("fill_count", k == 0 ? 32'(fill0) : 32'(fill1), q[k].size());
    chk("overflow", {31'b0, overflow[k]}, {31'b0, eovf[k]});
    chk("underflow", {31'b0, underflow[k]}, {31'b0, eunf[k]});
  endtask
  task automatic push(input int k, input logic [15:0] d);
    step(k, 0, 0, 1, d, 0, 0);
  endtask
  task automatic idle(input int k);
    step(k, 0, 0, 0, 16'h0, 0, 0);
  endtask
  task automatic wait_ready(input int k);
    int t;
    t = 0;
    while (ep_ready[k] !== 1'b1 && t < 8) begin idle(k); t++; end
    chk("ready_timeout", {31'b0, ep_ready[k]}, 32'd1);
  endtask
  initial begin
    @(posedge ti_clk); #1;
    step(0, 1, 0, 0, 16'h0, 0, 0);
    step(1, 1, 0, 0, 16'h0, 0, 0);
    step(0, 1, 0, 0, 16'h0, 0, 0);
    chk("rst_ready", {31'b0, ep_ready[0]}, 32'd0);
    chk("rst_datain", {16'b0, ep_datain[0]}, 32'd0);
    chk("rst_fill", 32'(fill0), 32'd0);
    chk("rst_flags", {30'b0, overflow[0], underflow[0]}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready[0]}, 32'd1);
    for (int i = 0; i < 255; i++) push(0, 16'(i));
    chk("fill_255", 32'(fill0), 32'd255);
    chk("no_ready_255", {31'b0, ep_ready[0]}, 32'd0);
    push(0, 16'd255);
    chk("ready_lag", {31'b0, ep_ready[0]}, 32'd0);
    idle(0);
    chk("ready_rise", {31'b0, ep_ready[0]}, 32'd1);
    step(0, 0, 0, 0, 16'h0, 0, 1);
    chk("strobe_fall", {31'b0, ep_ready[0]}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 0, 0, 16'h0, 1, 0);
      chk("blk_data", {16'b0, ep_datain[0]}, i);
    end
    chk("blk_fill", 32'(fill0), 32'd0);
    chk("blk_unf", {31'b0, underflow[0]}, 32'd0);
    idle(0);
    chk("blk_idle", {31'b0, ep_ready[0]}, 32'd0);
    for (int i = 0; i < 3; i++) push(0, 16'hA000 + 16'(i));
    step(0, 0, 0, 0, 16'h0, 1, 0);
    chk("unf_read_data", {16'b0, ep_datain[0]}, 32'd0);
    chk("unf_read_flag", {31'b0, underflow[0]}, 32'd1);
    chk("unf_read_fill", 32'(fill0), 32'd3);
    step(0, 0, 1, 0, 16'h0, 0, 0);
    step(0, 0, 0, 0, 16'h0, 0, 1);
    chk("unf_strobe", {31'b0, underflow[0]}, 32'd1);
    step(0, 0, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      push(1, 16'($urandom));
      if (i == 15) chk("full_in_ready", {31'b0, in_ready[1]}, 32'd0);
    end
    chk("ovf_flag", {31'b0, overflow[1]}, 32'd1);
    chk("ovf_fill", 32'(fill1), 32'd16);
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 4; b++) begin
        int g;
        wait_ready(1);
        step(1, 0, 0, 0, 16'h0, 0, 1);
        g = 0;
        while (mode[1] == 2 && g < 100) begin
          step(1, 0, 0, 0, 16'h0, $urandom_range(0, 3) != 0, 0);
          g++;
        end
      end
      chk("wrap_drain", 32'(fill1), 32'd0);
      while (q[1].size() < 16) step(1, 0, 0, 1'($urandom_range(0, 1)), 16'($urandom), 0, 0);
    end
    step(1, 0, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) push(1, 16'($urandom));
    for (int c = 0; c < 1000; c++)
      if (mode[1] == 1) step(1, 0, 0, 0, 16'h0, 0, 1);
      else if (mode[1] == 2) step(1, 0, 0, 1, 16'($urandom), 1, 0);
      else idle(1);
    chk("conc_fill", 32'(fill1), 32'd8);
    chk("conc_flags", {30'b0, overflow[1], underflow[1]}, 32'd0);
    step(0, 0, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 512; i++) push(0, 16'($urandom));
    wait_ready(0);
    step(0, 0, 0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 16'h0, 1, 0);
    step(0, 0, 1, 0, 16'h0, 1, 0);
    chk("abort_fill", 32'(fill0), 32'd0);
    chk("abort_ready", {31'b0, ep_ready[0]}, 32'd0);
    chk("abort_flags", {30'b0, overflow[0], underflow[0]}, 32'd0);
    for (int i = 0; i < 256; i++) push(0, 16'hC000 ^ 16'(i));
    wait_ready(0);
    step(0, 0, 0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 0, 0, 16'h0, 1, 0);
      chk("abort_next_blk", {16'b0, ep_datain[0]}, {16'b0, 16'hC000 ^ 16'(i)});
    end
    for (int c = 0; c < 400; c++)
      step(1, 0, $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), 16'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
